wb_core_bus_arbiter: RTL and testbench

- Shares one Wishbone B3 slave port between the two CPU masters of a processor tile: instruction bus (iwb) and data bus (dwb).
- Round-robin arbitration; a grant is held for the master's whole cycle, including registered-feedback bursts.
- Watchdog terminates slave cycles that hang.
- Emits a one-cycle snoop pulse for each acknowledged data write, for peer-core dcache invalidation.

---
 rtl/wb_arb_pkg.sv | 24 ++
 rtl/wb_core_bus_arbiter_watchdog.sv | 42 ++++
 rtl/wb_core_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_wb_core_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the tile bus arbiter.
// Grant states, Wishbone cycle types and a width helper.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_core_bus_arbiter_watchdog.sv
// Stall watchdog for the shared slave port.
// Fires a one-cycle timeout after TIMEOUT_CYCLES unanswered strobes.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic resp,
    input  logic clear,
    output logic timeout
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : clog2(TIMEOUT_CYCLES);
    localparam bit WD_ON = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          hit;

    assign hit = WD_ON && stb && !resp && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign timeout = hit;

    // Count stalled strobe cycles; any response, idle or grant change restarts.
    always_comb begin
        cnt_d = cnt_q;
        if (!WD_ON || clear || !stb || resp || hit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb_core_bus_arbiter.sv
// Round-robin Wishbone arbiter: instruction and data master onto one slave.
// Holds grant for whole cycles, kills hung slaves, snoops data writes.
module wb_core_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter     SNOOP_EN       = "ENABLED",
    localparam int SELW          = DW / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   iwb_adr_i,
    input  logic [DW-1:0]   iwb_dat_i,
    input  logic [SELW-1:0] iwb_sel_i,
    input  logic            iwb_we_i,
    input  logic [2:0]      iwb_cti_i,
    input  logic [1:0]      iwb_bte_i,
    input  logic            iwb_cyc_i,
    input  logic            iwb_stb_i,
    output logic [DW-1:0]   iwb_dat_o,
    output logic            iwb_ack_o,
    output logic            iwb_err_o,
    output logic            iwb_rty_o,
    input  logic [AW-1:0]   dwb_adr_i,
    input  logic [DW-1:0]   dwb_dat_i,
    input  logic [SELW-1:0] dwb_sel_i,
    input  logic            dwb_we_i,
    input  logic [2:0]      dwb_cti_i,
    input  logic [1:0]      dwb_bte_i,
    input  logic            dwb_cyc_i,
    input  logic            dwb_stb_i,
    output logic [DW-1:0]   dwb_dat_o,
    output logic            dwb_ack_o,
    output logic            dwb_err_o,
    output logic            dwb_rty_o,
    output logic [AW-1:0]   swb_adr_o,
    output logic [DW-1:0]   swb_dat_o,
    output logic [SELW-1:0] swb_sel_o,
    output logic            swb_we_o,
    output logic [2:0]      swb_cti_o,
    output logic [1:0]      swb_bte_o,
    output logic            swb_cyc_o,
    output logic            swb_stb_o,
    input  logic [DW-1:0]   swb_dat_i,
    input  logic            swb_ack_i,
    input  logic            swb_err_i,
    input  logic            swb_rty_i,
    output logic [AW-1:0]   snoop_adr_o,
    output logic            snoop_en_o
);

    localparam bit SNOOP_ON = (SNOOP_EN == "ENABLED");

    state_t          state_q;
    state_t          state_d;
    logic            last_d_q;
    logic            last_d_d;
    logic            snoop_en_q;
    logic            snoop_en_d;
    logic [AW-1:0]   snoop_adr_q;
    logic [AW-1:0]   snoop_adr_d;
    logic            gnt_i;
    logic            gnt_d;
    logic            stb_raw;
    logic            resp;
    logic            timeout;

    assign gnt_i   = (state_q == ST_GNT_I);
    assign gnt_d   = (state_q == ST_GNT_D);
    assign resp    = swb_ack_i | swb_err_i | swb_rty_i;
    assign stb_raw = (gnt_i & iwb_cyc_i & iwb_stb_i) |
                     (gnt_d & dwb_cyc_i & dwb_stb_i);

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .stb    (stb_raw),
        .resp   (resp),
        .clear  (state_q != state_d),
        .timeout(timeout)
    );

    // Grant FSM: hold for the whole master cycle, hand over without a bubble.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        unique case (state_q)
            ST_IDLE: begin
                if (iwb_cyc_i && dwb_cyc_i) begin
                    state_d = last_d_q ? ST_GNT_I : ST_GNT_D;
                end else if (iwb_cyc_i) begin
                    state_d = ST_GNT_I;
                end else if (dwb_cyc_i) begin
                    state_d = ST_GNT_D;
                end
            end
            ST_GNT_I: begin
                if (!iwb_cyc_i) begin
                    last_d_d = 1'b0;
                    state_d  = dwb_cyc_i ? ST_GNT_D : ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (!dwb_cyc_i) begin
                    last_d_d = 1'b1;
                    state_d  = iwb_cyc_i ? ST_GNT_I : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant and last-grant pointer; D as last winner lets I win the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Slave-side mux; a timeout drops cyc/stb in the cycle it fires.
    always_comb begin
        swb_adr_o = '0;
        swb_dat_o = '0;
        swb_sel_o = '0;
        swb_we_o  = 1'b0;
        swb_cti_o = '0;
        swb_bte_o = '0;
        swb_cyc_o = 1'b0;
        swb_stb_o = 1'b0;
        if (gnt_i) begin
            swb_adr_o = iwb_adr_i;
            swb_dat_o = iwb_dat_i;
            swb_sel_o = iwb_sel_i;
            swb_we_o  = iwb_we_i;
            swb_cti_o = iwb_cti_i;
            swb_bte_o = iwb_bte_i;
            swb_cyc_o = iwb_cyc_i & ~timeout;
            swb_stb_o = iwb_stb_i & ~timeout;
        end else if (gnt_d) begin
            swb_adr_o = dwb_adr_i;
            swb_dat_o = dwb_dat_i;
            swb_sel_o = dwb_sel_i;
            swb_we_o  = dwb_we_i;
            swb_cti_o = dwb_cti_i;
            swb_bte_o = dwb_bte_i;
            swb_cyc_o = dwb_cyc_i & ~timeout;
            swb_stb_o = dwb_stb_i & ~timeout;
        end
    end

    assign iwb_dat_o = swb_dat_i;
    assign dwb_dat_o = swb_dat_i;
    assign iwb_ack_o = gnt_i & swb_ack_i;
    assign iwb_err_o = gnt_i & (swb_err_i | timeout);
    assign iwb_rty_o = gnt_i & swb_rty_i;
    assign dwb_ack_o = gnt_d & swb_ack_i;
    assign dwb_err_o = gnt_d & (swb_err_i | timeout);
    assign dwb_rty_o = gnt_d & swb_rty_i;

    // Snoop capture: one pulse per acked data write, address held after.
    always_comb begin
        snoop_en_d  = gnt_d & dwb_we_i & swb_ack_i;
        snoop_adr_d = snoop_en_d ? dwb_adr_i : snoop_adr_q;
    end

    // Snoop registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            snoop_en_q  <= 1'b0;
            snoop_adr_q <= '0;
        end else begin
            snoop_en_q  <= snoop_en_d;
            snoop_adr_q <= snoop_adr_d;
        end
    end

    assign snoop_en_o  = SNOOP_ON ? snoop_en_q : 1'b0;
    assign snoop_adr_o = SNOOP_ON ? snoop_adr_q : '0;

endmodule

// File: tb/tb_wb_core_bus_arbiter.sv
// Directed bench for wb_core_bus_arbiter.
// Expected responses queued by cycle; a negedge monitor matches them.
module tb_wb_core_bus_arbiter;
    import wb_arb_pkg::*;

    localparam int K_IACK = 0;
    localparam int K_IERR = 1;
    localparam int K_DACK = 2;
    localparam int K_DERR = 3;
    localparam int K_SNP  = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] d;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] iwb_adr_i, iwb_dat_i, iwb_dat_o;
    logic [3:0]  iwb_sel_i;
    logic        iwb_we_i, iwb_cyc_i, iwb_stb_i;
    logic [2:0]  iwb_cti_i;
    logic [1:0]  iwb_bte_i;
    logic        iwb_ack_o, iwb_err_o, iwb_rty_o;
    logic [31:0] dwb_adr_i, dwb_dat_i, dwb_dat_o;
    logic [3:0]  dwb_sel_i;
    logic        dwb_we_i, dwb_cyc_i, dwb_stb_i;
    logic [2:0]  dwb_cti_i;
    logic [1:0]  dwb_bte_i;
    logic        dwb_ack_o, dwb_err_o, dwb_rty_o;
    logic [31:0] swb_adr_o, swb_dat_o, swb_dat_i;
    logic [3:0]  swb_sel_o;
    logic        swb_we_o, swb_cyc_o, swb_stb_o;
    logic [2:0]  swb_cti_o;
    logic [1:0]  swb_bte_o;
    logic        swb_ack_i, swb_err_i, swb_rty_i;
    logic [31:0] snoop_adr_o;
    logic        snoop_en_o;

    int   vectors;
    int   miss;
    int   cyc_n;
    exp_t sb[$];

    wb_core_bus_arbiter #(
        .AW(32), .DW(32), .TIMEOUT_CYCLES(8), .SNOOP_EN("ENABLED")
    ) dut (
        .clk(clk), .rst(rst),
        .iwb_adr_i(iwb_adr_i), .iwb_dat_i(iwb_dat_i), .iwb_sel_i(iwb_sel_i),
        .iwb_we_i(iwb_we_i), .iwb_cti_i(iwb_cti_i), .iwb_bte_i(iwb_bte_i),
        .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i), .iwb_dat_o(iwb_dat_o),
        .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o), .iwb_rty_o(iwb_rty_o),
        .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_sel_i(dwb_sel_i),
        .dwb_we_i(dwb_we_i), .dwb_cti_i(dwb_cti_i), .dwb_bte_i(dwb_bte_i),
        .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i), .dwb_dat_o(dwb_dat_o),
        .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o), .dwb_rty_o(dwb_rty_o),
        .swb_adr_o(swb_adr_o), .swb_dat_o(swb_dat_o), .swb_sel_o(swb_sel_o),
        .swb_we_o(swb_we_o), .swb_cti_o(swb_cti_o), .swb_bte_o(swb_bte_o),
        .swb_cyc_o(swb_cyc_o), .swb_stb_o(swb_stb_o), .swb_dat_i(swb_dat_i),
        .swb_ack_i(swb_ack_i), .swb_err_i(swb_err_i), .swb_rty_i(swb_rty_i),
        .snoop_adr_o(snoop_adr_o), .snoop_en_o(snoop_en_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc_n = 0;
    always @(posedge clk) cyc_n++;

    function automatic string kname(input int k);
        case (k)
            K_IACK:  return "iwb_ack";
            K_IERR:  return "iwb_err";
            K_DACK:  return "dwb_ack";
            K_DERR:  return "dwb_err";
            default: return "snoop";
        endcase
    endfunction

    task automatic expect_ev(input int k, input int c, input logic [31:0] d);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        e.d    = d;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int k, input logic ev, input logic [31:0] d);
        int idx;
        if (ev !== 1'b1) return;
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].kind == k) idx = i;
        vectors++;
        if (idx < 0) begin
            miss++;
            $display("FAIL %s unexpected at cycle %0d data=%h", kname(k), cyc_n, d);
        end else begin
            if (sb[idx].cyc != cyc_n || sb[idx].d !== d) begin
                miss++;
                $display("FAIL %s got cycle %0d data=%h, want cycle %0d data=%h",
                         kname(k), cyc_n, d, sb[idx].cyc, sb[idx].d);
            end
            sb.delete(idx);
        end
    endtask

    // Monitor: match every presented response, then flag overdue ones.
    always @(negedge clk) begin
        check_ev(K_IACK, iwb_ack_o, iwb_dat_o);
        check_ev(K_IERR, iwb_err_o, 32'd0);
        check_ev(K_DACK, dwb_ack_o, dwb_dat_o);
        check_ev(K_DERR, dwb_err_o, 32'd0);
        check_ev(K_SNP, snoop_en_o, snoop_adr_o);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc_n) begin
                vectors++;
                miss++;
                $display("FAIL %s missing, wanted at cycle %0d data=%h",
                         kname(sb[i].kind), sb[i].cyc, sb[i].d);
                sb.delete(i);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_m();
        iwb_adr_i = '0; iwb_dat_i = '0; iwb_sel_i = 4'hf; iwb_we_i = 1'b0;
        iwb_cti_i = CLASSIC; iwb_bte_i = '0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
        dwb_adr_i = '0; dwb_dat_i = '0; dwb_sel_i = 4'hf; dwb_we_i = 1'b0;
        dwb_cti_i = CLASSIC; dwb_bte_i = '0; dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
        swb_dat_i = '0; swb_ack_i = 1'b0; swb_err_i = 1'b0; swb_rty_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr_m();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic d_req(input logic [31:0] a, input logic we);
        dwb_adr_i = a; dwb_we_i = we; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    endtask

    task automatic i_req(input logic [31:0] a, input logic we);
        iwb_adr_i = a; iwb_we_i = we; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    endtask

    task automatic ack(input logic [31:0] d);
        swb_ack_i = 1'b1;
        swb_dat_i = d;
    endtask

    initial begin
        vectors = 0;
        miss    = 0;
        rst     = 1'b0;
        clr_m();
        tick(); tick(); tick();
        #3;
        chk("rst_cyc", 32'(swb_cyc_o), 32'd0);
        chk("rst_stb", 32'(swb_stb_o), 32'd0);
        chk("rst_we", 32'(swb_we_o), 32'd0);
        chk("rst_snp_en", 32'(snoop_en_o), 32'd0);
        chk("rst_snp_adr", snoop_adr_o, 32'd0);
        rst = 1'b1;

        // single dwb read
        tick();
        d_req(32'h100, 1'b0);
        #3 chk("t1_c0_cyc", 32'(swb_cyc_o), 32'd0);
        tick();
        #3 chk("t1_c1_cyc", 32'(swb_cyc_o), 32'd1);
        chk("t1_c1_adr", swb_adr_o, 32'h100);
        tick();
        tick();
        ack(32'hDEADBEEF);
        expect_ev(K_DACK, cyc_n, 32'hDEADBEEF);
        #3 chk("t1_bcast", iwb_dat_o, 32'hDEADBEEF);
        tick(); clr_m();
        tick();

        // arbitration out of reset
        do_reset();
        i_req(32'h200, 1'b0);
        d_req(32'h300, 1'b0);
        tick();
        ack(32'h11);
        expect_ev(K_IACK, cyc_n, 32'h11);
        #3 chk("t2_first_i", swb_adr_o, 32'h200);
        tick();
        swb_ack_i = 1'b0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
        #3 chk("t2_i_drop", 32'(swb_cyc_o), 32'd0);
        tick();
        ack(32'h22);
        expect_ev(K_DACK, cyc_n, 32'h22);
        #3 chk("t2_switch_cyc", 32'(swb_cyc_o), 32'd1);
        chk("t2_switch_d", swb_adr_o, 32'h300);
        tick(); clr_m();
        tick();
        i_req(32'h210, 1'b0);
        tick();
        ack(32'h33);
        expect_ev(K_IACK, cyc_n, 32'h33);
        #3 chk("t2_i_alone", swb_adr_o, 32'h210);
        tick(); clr_m();
        tick();
        i_req(32'h220, 1'b0);
        d_req(32'h320, 1'b0);
        tick();
        ack(32'h44);
        expect_ev(K_DACK, cyc_n, 32'h44);
        #3 chk("t2_d_wins", swb_adr_o, 32'h320);
        tick(); clr_m();
        tick();

        // iwb 4-beat burst with dwb waiting
        i_req(32'h400, 1'b0);
        iwb_cti_i = INCR;
        d_req(32'h500, 1'b0);
        for (int b = 0; b < 4; b++) begin
            tick();
            iwb_adr_i = 32'h400 + b;
            iwb_cti_i = (b == 3) ? EOB : INCR;
            ack(32'h1000 + b);
            expect_ev(K_IACK, cyc_n, 32'h1000 + b);
            #3 chk("t3_beat_adr", swb_adr_o, 32'h400 + b);
            chk("t3_beat_cti", 32'(swb_cti_o), 32'((b == 3) ? EOB : INCR));
        end
        tick();
        swb_ack_i = 1'b0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
        iwb_cti_i = CLASSIC;
        #3 chk("t3_no_preempt", 32'(swb_cyc_o), 32'd0);
        tick();
        ack(32'h55);
        expect_ev(K_DACK, cyc_n, 32'h55);
        #3 chk("t3_then_d", swb_adr_o, 32'h500);
        tick(); clr_m();
        tick();

        // snoop on data write only
        d_req(32'h1234, 1'b1);
        dwb_dat_i = 32'hCAFE;
        tick();
        ack(32'h0);
        expect_ev(K_DACK, cyc_n, 32'h0);
        expect_ev(K_SNP, cyc_n + 1, 32'h1234);
        #3 chk("t4_we", 32'(swb_we_o), 32'd1);
        chk("t4_wdat", swb_dat_o, 32'hCAFE);
        tick(); clr_m();
        tick();
        #3 chk("t4_snp_low", 32'(snoop_en_o), 32'd0);
        chk("t4_snp_hold", snoop_adr_o, 32'h1234);
        d_req(32'h1234, 1'b0);
        tick();
        ack(32'h66);
        expect_ev(K_DACK, cyc_n, 32'h66);
        tick(); clr_m();
        tick();
        i_req(32'h1234, 1'b1);
        tick();
        ack(32'h77);
        expect_ev(K_IACK, cyc_n, 32'h77);
        tick(); clr_m();
        tick();
        d_req(32'h2000, 1'b1);
        dwb_cti_i = INCR;
        tick();
        ack(32'h0);
        expect_ev(K_DACK, cyc_n, 32'h0);
        expect_ev(K_SNP, cyc_n + 1, 32'h2000);
        tick();
        dwb_adr_i = 32'h2001;
        dwb_cti_i = EOB;
        expect_ev(K_DACK, cyc_n, 32'h0);
        expect_ev(K_SNP, cyc_n + 1, 32'h2001);
        tick(); clr_m();
        tick(); tick();

        // watchdog: slave silent
        d_req(32'h600, 1'b0);
        for (int k = 1; k < 8; k++) begin
            tick();
            #3 chk("t5_stall_stb", 32'(swb_stb_o), 32'd1);
        end
        tick();
        expect_ev(K_DERR, cyc_n, 32'd0);
        #3 chk("t5_to_stb", 32'(swb_stb_o), 32'd0);
        chk("t5_to_cyc", 32'(swb_cyc_o), 32'd0);
        tick(); clr_m();
        tick(); tick();

        // watchdog: ack lands in the timeout cycle
        d_req(32'h610, 1'b0);
        for (int k = 1; k < 8; k++) tick();
        tick();
        ack(32'hABCD);
        expect_ev(K_DACK, cyc_n, 32'hABCD);
        #3 chk("t5_ack_stb", 32'(swb_stb_o), 32'd1);
        tick(); clr_m();
        tick(); tick();

        // reset during second beat of a dwb write burst
        d_req(32'h700, 1'b1);
        dwb_cti_i = INCR;
        tick();
        ack(32'h0);
        expect_ev(K_DACK, cyc_n, 32'h0);
        expect_ev(K_SNP, cyc_n + 1, 32'h700);
        tick();
        swb_ack_i = 1'b0;
        dwb_adr_i = 32'h701;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i_req(32'h800, 1'b0);
        #3 chk("t6_cyc", 32'(swb_cyc_o), 32'd0);
        chk("t6_snp_en", 32'(snoop_en_o), 32'd0);
        chk("t6_snp_adr", snoop_adr_o, 32'd0);
        tick();
        ack(32'h88);
        expect_ev(K_IACK, cyc_n, 32'h88);
        #3 chk("t6_i_first", swb_adr_o, 32'h800);
        chk("t6_i_cyc", 32'(swb_cyc_o), 32'd1);
        tick(); clr_m();
        tick(); tick();

        #3 chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
